// File: rtl/eeprom_pkg.sv
// eeprom_pkg: constants and state encoding shared by the EEPROM page writer and page reader.
//   eeprom_state_e    - sequencer states (WRITE_CYCLE used only with EEPROM_WR_WAIT_EN)
//   I2C_READ/WRITE    - value of the I2C master's rw bit
//   EEPROM_ADDR_BYTES - memory-address bytes sent ahead of the data
//   clamp_nbytes()    - maps a requested byte count onto 1..page_bytes
package eeprom_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        START       = 3'd1,
        WRITE_ADDR  = 3'd2,
        WRITE_DATA  = 3'd3,
        WAIT_DONE   = 3'd4,
        WRITE_CYCLE = 3'd5
    } eeprom_state_e;

    localparam logic I2C_READ  = 1'b1;
    localparam logic I2C_WRITE = 1'b0;

    localparam int unsigned EEPROM_ADDR_BYTES = 2;

    // 0 or anything larger than a page means "the whole page".
    function automatic logic [7:0] clamp_nbytes(input logic [7:0] n,
                                                input logic [7:0] page_bytes);
        if (n == 8'd0 || n > page_bytes) begin
            return page_bytes;
        end
        return n;
    endfunction

endpackage

// File: rtl/eeprom_wr_timer.sv
// eeprom_wr_timer: down-counter that times the EEPROM internal write cycle (tWR).
//   clk, reset  - clock, synchronous active-high reset
//   i_load      - load i_load_val this cycle
//   i_load_val  - start value, normally cycle count - 1
//   o_expire    - high in the cycle the counter steps onto zero (or sits at zero)
module eeprom_wr_timer #(
    parameter int unsigned W = 18
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_expire
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Flag one cycle early so the owner's registered done lands as the count reaches zero.
    assign o_expire = (r_count == W'(1)) || (r_count == '0);

endmodule

// File: rtl/write_eeprom.sv
// write_eeprom: writes up to one page to an I2C EEPROM through a shared I2C master.
// Sends one write transfer: memory address high, low, then N bytes from a show-ahead source.
// Inputs : clk, reset (sync, active-high), start, slave_addr_w, page_addr_w, write_nbytes_w,
//          data_in (show-ahead source), i2c_tx_data_req, i2c_busy (from the I2C master)
// Outputs: busy, done, byte_taken (source advance strobe), i2c_start, i2c_slave_addr, i2c_rw,
//          i2c_write_data, i2c_nbytes (to the I2C master)
// Build option: define EEPROM_WR_WAIT_EN to hold busy through the WRITE_CYCLE_CLKS-long tWR.
module write_eeprom
    import eeprom_pkg::*;
#(
    parameter int unsigned PAGE_BYTES       = 32,
    parameter int unsigned WRITE_CYCLE_CLKS = 250000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  slave_addr_w,
    input  logic [15:0] page_addr_w,
    input  logic [7:0]  write_nbytes_w,
    input  logic        start,
    input  logic [7:0]  data_in,
    output logic        byte_taken,
    output logic        busy,
    output logic        done,
    output logic [6:0]  i2c_slave_addr,
    output logic        i2c_rw,
    output logic [7:0]  i2c_write_data,
    output logic [7:0]  i2c_nbytes,
    input  logic        i2c_tx_data_req,
    input  logic        i2c_busy,
    output logic        i2c_start
);

    localparam int unsigned PAGE_BITS    = $clog2(PAGE_BYTES);
    localparam logic [7:0]  PAGE_BYTES_B = 8'(PAGE_BYTES);

    eeprom_state_e r_state, w_state_d;
    logic [15:0]   r_mem_addr, w_mem_addr_d;
    logic [7:0]    r_nbytes, w_nbytes_d;
    logic [7:0]    r_byte_count, w_byte_count_d;
    logic [6:0]    r_slave, w_slave_d;
    logic          r_waiting, w_waiting_d;
    logic          r_addr_lo, w_addr_lo_d;
    logic [6:0]    r_i2c_slave_addr, w_i2c_slave_addr_d;
    logic [7:0]    r_i2c_nbytes, w_i2c_nbytes_d;
    logic [7:0]    r_i2c_write_data, w_i2c_write_data_d;
    logic          r_i2c_start, w_i2c_start_d;
    logic          r_busy, w_busy_d;
    logic          r_done, w_done_d;
    logic          r_byte_taken, w_byte_taken_d;
    logic          w_req_rise;

    // A request held high is serviced once; it must drop before the next one counts.
    assign w_req_rise = i2c_tx_data_req & ~r_waiting;

`ifdef EEPROM_WR_WAIT_EN
    localparam int unsigned TIMER_W = (WRITE_CYCLE_CLKS > 1) ? $clog2(WRITE_CYCLE_CLKS) : 1;
    logic w_timer_load;
    logic w_timer_expire;

    eeprom_wr_timer #(
        .W (TIMER_W)
    ) u_wr_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_timer_load),
        .i_load_val (TIMER_W'(WRITE_CYCLE_CLKS - 1)),
        .o_expire   (w_timer_expire)
    );
`else
    logic w_unused_wr_clks;
    assign w_unused_wr_clks = WRITE_CYCLE_CLKS[0];
`endif

    always_comb begin
        w_state_d          = r_state;
        w_mem_addr_d       = r_mem_addr;
        w_nbytes_d         = r_nbytes;
        w_byte_count_d     = r_byte_count;
        w_slave_d          = r_slave;
        w_waiting_d        = r_waiting & i2c_tx_data_req;
        w_addr_lo_d        = r_addr_lo;
        w_i2c_slave_addr_d = r_i2c_slave_addr;
        w_i2c_nbytes_d     = r_i2c_nbytes;
        w_i2c_write_data_d = r_i2c_write_data;
        w_i2c_start_d      = r_i2c_start;
        w_busy_d           = r_busy;
        w_done_d           = 1'b0;
        w_byte_taken_d     = 1'b0;
`ifdef EEPROM_WR_WAIT_EN
        w_timer_load       = 1'b0;
`endif

        unique case (r_state)
            IDLE: begin
                w_busy_d = 1'b0;
                if (start) begin
                    w_slave_d    = slave_addr_w;
                    w_mem_addr_d = page_addr_w << PAGE_BITS;
                    w_nbytes_d   = clamp_nbytes(write_nbytes_w, PAGE_BYTES_B);
                    w_busy_d     = 1'b1;
                    w_state_d    = START;
                end
            end
            START: begin
                if (!i2c_busy) begin
                    w_i2c_slave_addr_d = r_slave;
                    w_i2c_nbytes_d     = r_nbytes + 8'(EEPROM_ADDR_BYTES);
                    w_i2c_start_d      = 1'b1;
                    w_byte_count_d     = 8'd0;
                    w_waiting_d        = 1'b0;
                    w_addr_lo_d        = 1'b0;
                    w_state_d          = WRITE_ADDR;
                end
            end
            WRITE_ADDR: begin
                if (w_req_rise) begin
                    w_waiting_d = 1'b1;
                    if (!r_addr_lo) begin
                        w_i2c_write_data_d = r_mem_addr[15:8];
                        w_addr_lo_d        = 1'b1;
                    end else begin
                        w_i2c_write_data_d = r_mem_addr[7:0];
                        w_state_d          = WRITE_DATA;
                    end
                end
            end
            WRITE_DATA: begin
                if (w_req_rise) begin
                    w_waiting_d        = 1'b1;
                    w_i2c_write_data_d = data_in;
                    w_byte_taken_d     = 1'b1;
                    w_byte_count_d     = r_byte_count + 8'd1;
                    if (r_byte_count == r_nbytes - 8'd1) begin
                        w_i2c_start_d = 1'b0;
                        w_state_d     = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!i2c_busy) begin
`ifdef EEPROM_WR_WAIT_EN
                    w_timer_load = 1'b1;
                    w_state_d    = WRITE_CYCLE;
`else
                    w_done_d  = 1'b1;
                    w_busy_d  = 1'b0;
                    w_state_d = IDLE;
`endif
                end
            end
`ifdef EEPROM_WR_WAIT_EN
            WRITE_CYCLE: begin
                if (w_timer_expire) begin
                    w_done_d  = 1'b1;
                    w_busy_d  = 1'b0;
                    w_state_d = IDLE;
                end
            end
`endif
            default: begin
                w_busy_d      = 1'b0;
                w_i2c_start_d = 1'b0;
                w_state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_mem_addr       <= '0;
            r_nbytes         <= '0;
            r_byte_count     <= '0;
            r_slave          <= '0;
            r_waiting        <= 1'b0;
            r_addr_lo        <= 1'b0;
            r_i2c_slave_addr <= '0;
            r_i2c_nbytes     <= '0;
            r_i2c_write_data <= '0;
            r_i2c_start      <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_byte_taken     <= 1'b0;
        end else begin
            r_state          <= w_state_d;
            r_mem_addr       <= w_mem_addr_d;
            r_nbytes         <= w_nbytes_d;
            r_byte_count     <= w_byte_count_d;
            r_slave          <= w_slave_d;
            r_waiting        <= w_waiting_d;
            r_addr_lo        <= w_addr_lo_d;
            r_i2c_slave_addr <= w_i2c_slave_addr_d;
            r_i2c_nbytes     <= w_i2c_nbytes_d;
            r_i2c_write_data <= w_i2c_write_data_d;
            r_i2c_start      <= w_i2c_start_d;
            r_busy           <= w_busy_d;
            r_done           <= w_done_d;
            r_byte_taken     <= w_byte_taken_d;
        end
    end

    assign byte_taken     = r_byte_taken;
    assign busy           = r_busy;
    assign done           = r_done;
    assign i2c_slave_addr = r_i2c_slave_addr;
    assign i2c_rw         = I2C_WRITE;
    assign i2c_write_data = r_i2c_write_data;
    assign i2c_nbytes     = r_i2c_nbytes;
    assign i2c_start      = r_i2c_start;

endmodule

// File: tb/tb_write_eeprom.sv
// tb_write_eeprom: directed self-checking bench for write_eeprom (PAGE_BYTES=32).
// Models the I2C master and a show-ahead data source; honours EEPROM_WR_WAIT_EN when defined.
module tb_write_eeprom;

    localparam int PAGE = 32;
    localparam int WCC  = 100;
`ifdef EEPROM_WR_WAIT_EN
    localparam int EXP_LAT = WCC;
`else
    localparam int EXP_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  slave_addr_w = '0;
    logic [15:0] page_addr_w = '0;
    logic [7:0]  write_nbytes_w = '0;
    logic        start = 1'b0;
    logic [7:0]  data_in;
    logic        byte_taken, busy, done;
    logic [6:0]  i2c_slave_addr;
    logic        i2c_rw;
    logic [7:0]  i2c_write_data, i2c_nbytes;
    logic        i2c_tx_data_req = 1'b0;
    logic        i2c_busy = 1'b0;
    logic        i2c_start;

    logic [7:0] src_data [0:31];
    int         taken_cnt = 0;
    int         done_cnt = 0;
    logic       clr = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    write_eeprom #(
        .PAGE_BYTES       (PAGE),
        .WRITE_CYCLE_CLKS (WCC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .slave_addr_w    (slave_addr_w),
        .page_addr_w     (page_addr_w),
        .write_nbytes_w  (write_nbytes_w),
        .start           (start),
        .data_in         (data_in),
        .byte_taken      (byte_taken),
        .busy            (busy),
        .done            (done),
        .i2c_slave_addr  (i2c_slave_addr),
        .i2c_rw          (i2c_rw),
        .i2c_write_data  (i2c_write_data),
        .i2c_nbytes      (i2c_nbytes),
        .i2c_tx_data_req (i2c_tx_data_req),
        .i2c_busy        (i2c_busy),
        .i2c_start       (i2c_start)
    );

    // Show-ahead source: advances one entry per byte_taken strobe.
    assign data_in = src_data[taken_cnt & 31];

    always @(posedge clk) begin
        if (clr) begin
            taken_cnt <= 0;
            done_cnt  <= 0;
        end else begin
            if (byte_taken) taken_cnt <= taken_cnt + 1;
            if (done)       done_cnt  <= done_cnt + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One write transfer driven end to end. poke_at / abort_at give the tx byte index after
    // which a stray start is pulsed / reset is asserted (-1 disables).
    task automatic run_xfer(input string name, input logic [6:0] slave, input logic [15:0] page,
                            input logic [7:0] n, input int hold, input int poke_at,
                            input int abort_at);
        int          nn;
        int          total;
        int          lat;
        int          wait_c;
        bit          busy_dropped;
        logic [15:0] mem;
        logic [7:0]  exp_b;
        nn  = (n == 0 || n > PAGE) ? PAGE : int'(n);
        mem = page << 5;
        clr = 1'b1; tick; clr = 1'b0;
        slave_addr_w = slave; page_addr_w = page; write_nbytes_w = n; start = 1'b1;
        tick;
        start = 1'b0; slave_addr_w = '0; page_addr_w = '0; write_nbytes_w = '0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        end
        wait_c = 0;
        while (i2c_start !== 1'b1 && wait_c < 50) begin tick; wait_c++; end
        checks++;
        if (i2c_start !== 1'b1) begin
            errors++; $display("FAIL %s i2c_start_timeout: got %b want 1", name, i2c_start);
            return;
        end
        checks++;
        if (i2c_slave_addr !== slave) begin
            errors++; $display("FAIL %s slave: got %h want %h", name, i2c_slave_addr, slave);
        end
        checks++;
        if (i2c_rw !== 1'b0) begin
            errors++; $display("FAIL %s rw: got %b want 0", name, i2c_rw);
        end
        checks++;
        if (i2c_nbytes !== 8'(nn + 2)) begin
            errors++; $display("FAIL %s nbytes: got %0d want %0d", name, i2c_nbytes, nn + 2);
        end
        i2c_busy = 1'b1;
        total = nn + 2;
        for (int k = 0; k < total; k++) begin
            tick; tick;
            i2c_tx_data_req = 1'b1;
            tick;
            exp_b = (k == 0) ? mem[15:8] : (k == 1) ? mem[7:0] : src_data[k-2];
            checks++;
            if (i2c_write_data !== exp_b) begin
                errors++;
                $display("FAIL %s byte%0d: got %h want %h", name, k, i2c_write_data, exp_b);
            end
            repeat (hold - 1) tick;
            i2c_tx_data_req = 1'b0;
            if (k == poke_at) begin
                start = 1'b1; slave_addr_w = 7'h22; page_addr_w = 16'h0009; write_nbytes_w = 8'd1;
                tick;
                start = 1'b0;
            end
            if (k == abort_at) begin
                reset = 1'b1;
                tick;
                checks += 3;
                if (i2c_start !== 1'b0) begin
                    errors++; $display("FAIL %s reset_i2c_start: got %b want 0", name, i2c_start);
                end
                if (busy !== 1'b0) begin
                    errors++; $display("FAIL %s reset_busy: got %b want 0", name, busy);
                end
                if (byte_taken !== 1'b0) begin
                    errors++; $display("FAIL %s reset_taken: got %b want 0", name, byte_taken);
                end
                reset = 1'b0; i2c_busy = 1'b0;
                tick;
                return;
            end
        end
        checks++;
        if (i2c_start !== 1'b0) begin
            errors++; $display("FAIL %s i2c_start_end: got %b want 0", name, i2c_start);
        end
        repeat (4) tick;
        checks++;
        if (busy !== 1'b1 || done_cnt != 0) begin
            errors++;
            $display("FAIL %s wait_done: got busy %b done %0d want 1 0", name, busy, done_cnt);
        end
        i2c_busy = 1'b0;
        lat = 0;
        busy_dropped = 1'b0;
        while (done !== 1'b1 && lat < 400) begin
            if (busy !== 1'b1) busy_dropped = 1'b1;
            tick;
            lat++;
        end
        checks++;
        if (lat != EXP_LAT) begin
            errors++; $display("FAIL %s done_latency: got %0d want %0d", name, lat, EXP_LAT);
        end
        checks++;
        if (busy_dropped || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_fall: got early %b end %b want 0 0", name, busy_dropped, busy);
        end
        repeat (3) tick;
        checks++;
        if (taken_cnt != nn) begin
            errors++; $display("FAIL %s taken_count: got %0d want %0d", name, taken_cnt, nn);
        end
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_once: got %0d busy %b want 1 0", name, done_cnt, busy);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick;
        reset = 1'b0;
        tick;
        checks++;
        if ({busy, done, byte_taken, i2c_start, i2c_rw} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000",
                     {busy, done, byte_taken, i2c_start, i2c_rw});
        end
        checks++;
        if ({i2c_slave_addr, i2c_write_data, i2c_nbytes} !== 23'b0) begin
            errors++;
            $display("FAIL reset_buses: got %h %h %h want 0 0 0",
                     i2c_slave_addr, i2c_write_data, i2c_nbytes);
        end
    endtask

    task automatic test_basic;
        src_data[0] = 8'hA1; src_data[1] = 8'hB2; src_data[2] = 8'hC3; src_data[3] = 8'hD4;
        run_xfer("basic", 7'h50, 16'd3, 8'd4, 1, -1, -1);
    endtask

    task automatic test_clamp;
        for (int i = 0; i < 32; i++) src_data[i] = 8'(i * 7 + 1);
        run_xfer("clamp_n0", 7'h51, 16'd5, 8'd0, 1, -1, -1);
        run_xfer("clamp_n40", 7'h57, 16'h07FF, 8'd40, 1, -1, -1);
    endtask

    task automatic test_start_ignored;
        for (int i = 0; i < 32; i++) src_data[i] = 8'(8'hF0 - i);
        run_xfer("start_ignored", 7'h50, 16'd1, 8'd6, 1, 3, -1);
    endtask

    task automatic test_req_hold;
        for (int i = 0; i < 32; i++) src_data[i] = 8'(i + 8'h30);
        run_xfer("req_hold", 7'h53, 16'd2, 8'd3, 5, -1, -1);
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 32; i++) src_data[i] = 8'(i ^ 8'h5A);
        run_xfer("reset_mid", 7'h54, 16'd4, 8'd8, 1, -1, 3);
        run_xfer("after_reset", 7'h55, 16'd6, 8'd2, 1, -1, -1);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_clamp;
        test_start_ignored;
        test_req_hold;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/write_eeprom.md
Name: write_eeprom

Overview:
Page writer for I2C EEPROMs and the write-side counterpart of the EEPROM page reader. It latches a slave address, page number and byte count, then drives the shared I2C master to send a single write transfer: two memory-address bytes followed by N data bytes. Data bytes are pulled from an upstream show-ahead source such as a FIFO or ROM. Sits beside the page reader on the same I2C master; an external arbiter grants only one of them at a time.

Parameters:
PAGE_BYTES, 32, EEPROM page size in bytes; power of two, 2..128.
WRITE_CYCLE_CLKS, 250000, clk cycles of internal EEPROM write time (tWR); used only with EEPROM_WR_WAIT_EN.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
slave_addr_w  in  7  device address, sampled on accepted start
page_addr_w  in  16  page number, sampled on accepted start
write_nbytes_w  in  8  data bytes to write; 0 or >PAGE_BYTES means PAGE_BYTES
start  in  1  request a page write; honoured only in IDLE
data_in  in  8  current data byte, show-ahead; must be valid while busy
byte_taken  out  1  1-cycle strobe: data_in was consumed; upstream advances
busy  out  1  high from the cycle after an accepted start until completion
done  out  1  1-cycle pulse on completion
i2c_slave_addr  out  7  to I2C master
i2c_rw  out  1  always 0 (write)
i2c_write_data  out  8  byte presented to master
i2c_nbytes  out  8  total transfer length = 2 + clamped N
i2c_tx_data_req  in  1  level request for the next tx byte
i2c_busy  in  1  master busy
i2c_start  out  1  held high for the whole transfer

Behaviour:
- Reset: all outputs 0, all internal registers 0, state IDLE. Reset mid-transfer drops i2c_start immediately; the EEPROM page may be left partially written; no recovery is attempted.
- Latched on an accepted start:
  - mem_addr = {page_addr_w[15-PAGE_BITS:0], PAGE_BITS zeros}, PAGE_BITS = clog2(PAGE_BYTES).
  - nbytes = clamped N (always 1..PAGE_BYTES).
  - busy goes high next cycle.
  - start while busy is ignored.
- IDLE: busy=0; on start -> START.
- START: wait !i2c_busy. Then set i2c_slave_addr, i2c_rw=0, i2c_nbytes=nbytes+2 (8-bit, no overflow since nbytes<=128), i2c_start=1, byte_count=0, waiting=0 -> WRITE_ADDR.
- WRITE_ADDR:
  - on i2c_tx_data_req rise (waiting=0 and req=1): load mem_addr[15:8], then mem_addr[7:0] on the next request; set waiting=1.
  - waiting clears when req=0.
  - after the low byte -> WRITE_DATA.
- WRITE_DATA:
  - same rise-detect handshake; on each request: i2c_write_data<=data_in, byte_taken=1 for that cycle, byte_count+1.
  - on byte_count==nbytes-1: also i2c_start<=0 -> WAIT_DONE.
  - exactly nbytes byte_taken strobes per transfer, never more.
- WAIT_DONE: wait i2c_busy==0 (the master is still busy shifting the last byte on entry). Without the macro: done=1, -> IDLE. With the macro: -> WRITE_CYCLE.
- Page wrap: mem_addr low bits are always 0 and nbytes <= PAGE_BYTES, so the EEPROM internal counter never wraps within the page.
- tx_data_req held high across states counts as one request only; a new request needs req low then high.

Optional Feature:
Macro EEPROM_WR_WAIT_EN.
- Defined: adds state WRITE_CYCLE. A counter loads WRITE_CYCLE_CLKS-1 on entry and decrements each cycle. At 0: done=1 -> IDLE. busy stays high throughout, so a following read or write cannot start during tWR.
- Undefined: no counter and no state. done is asserted in the cycle WAIT_DONE sees !i2c_busy; the user must guarantee the tWR gap.

Decomposition:
- Shared package eeprom_pkg:
  - state encodings (IDLE, START, WRITE_ADDR, WRITE_DATA, WAIT_DONE, WRITE_CYCLE)
  - I2C_READ=1, I2C_WRITE=0
  - EEPROM_ADDR_BYTES=2
  - the reader uses the same constants.
- One natural sub-module: eeprom_wr_timer (load/decrement/zero flag), instantiated only under EEPROM_WR_WAIT_EN.

Test Plan:
- PAGE_BYTES=32, slave 0x50, page 3, N=4, data A1 B2 C3 D4 -> i2c_nbytes=6, i2c_rw=0, tx bytes 00 60 A1 B2 C3 D4, 4 byte_taken strobes, one done pulse, busy low afterwards.
- N=0 and N=40 (PAGE_BYTES=32) -> i2c_nbytes=34, exactly 32 byte_taken strobes, address bytes reflect page<<5.
- start pulsed again during WRITE_DATA with different slave/page -> ignored; transfer bytes unchanged; only one done.
- tx_data_req held high 5 cycles per byte -> each byte loaded once; the counts above still hold.
- reset asserted after 2 data bytes -> next cycle: i2c_start=0, busy=0, byte_taken=0; a new start then completes normally.
- EEPROM_WR_WAIT_EN, WRITE_CYCLE_CLKS=100 -> done and busy-fall occur exactly 100 cycles after i2c_busy falls; without the macro, on the first cycle after i2c_busy falls.
